// File: rtl/tdm_mux_4to1.sv
`default_nettype none
// ============================================================================
// Module   : tdm_mux_4to1
// Purpose  : Four-channel time-division multiplexer. Each channel offers
//            beats over a valid/ready handshake; a round-robin arbiter with
//            burst locking picks one channel per cycle and forwards its beat
//            into a single registered output stage. Every output beat carries
//            a 2-bit select code {A,B} so the far-end 1x4 demux can route it
//            back to output Dn.
// Ports    : clk        rising-edge clock
//            rst        asynchronous active-high reset
//            in_valid   [3:0]        per-channel beat present
//            in_data    [4*WIDTH-1:0] channel n beat at [n*WIDTH +: WIDTH]
//            in_ready   [3:0]        per-channel beat accepted this cycle
//            out_valid  output register holds a beat
//            out_data   [WIDTH-1:0]  beat payload
//            out_sel    [1:0]        source channel code {A,B}
//            out_ready  downstream accepts the held beat this cycle
// Params   : WIDTH  data bits per beat
//            BURST  max consecutive beats granted to one channel (1..16)
// Revision : 1.0 - initial release
// ============================================================================
module tdm_mux_4to1 #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [4:0] BURST_CNT = 5'(BURST);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  state_t             state_q,     state_d;
  logic [1:0]         last_q,      last_d;
  logic [4:0]         cnt_q,       cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q,  out_data_d;
  logic [1:0]         out_sel_q,   out_sel_d;

  // --------------------------------------------------------------------------
  // Combinational arbitration signals
  // --------------------------------------------------------------------------
  logic               load;
  logic               found;
  logic [1:0]         chosen;
  logic               xfer;
  logic [2:0]         rr_result;
  logic [WIDTH-1:0]   sel_data;

  // Round-robin search starting one past the previous owner. The loop walks
  // offsets from farthest to nearest so the nearest requester wins; offset 4
  // wraps to the previous owner itself, which therefore has lowest priority.
  function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] prev);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    idx = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = prev + 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // The output stage may take a new beat when empty or being drained.
  assign load = ~out_valid_q | out_ready;

  always_comb begin
    rr_result = rr_pick(in_valid, last_q);
    chosen    = 2'd0;
    found     = 1'b0;
    if (state_q == LOCK) begin
      // Burst owner keeps the link only while it keeps offering beats.
      chosen = last_q;
      found  = in_valid[last_q];
    end else begin
      chosen = rr_result[1:0];
      found  = rr_result[2];
    end
  end

  // rst is included so no channel sees a handshake while the block is
  // held in reset (the cleared output stage would otherwise look loadable).
  assign xfer     = load & found & ~rst;
  assign sel_data = in_data[chosen*WIDTH +: WIDTH];

  generate
    for (genvar n = 0; n < 4; n++) begin : g_ready
      assign in_ready[n] = xfer & (chosen == 2'(n));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state and output-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;

    if (load) begin
      if (xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_sel_d   = chosen;
      end else begin
        // Held beat (if any) is consumed and nothing replaces it.
        out_valid_d = 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            last_d  = chosen;
            cnt_d   = 5'd1;
            state_d = (BURST > 1) ? LOCK : IDLE;
          end
        end
        LOCK: begin
          if (xfer) begin
            cnt_d = cnt_q + 5'd1;
            if ((cnt_q + 5'd1) == BURST_CNT) begin
              state_d = IDLE;
            end
          end else begin
            // Owner went quiet: release the lock. This costs one bubble
            // and arbitration resumes one past the owner next cycle.
            cnt_d   = 5'd0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 2'd3;  // so the first search after reset starts at ch0
      cnt_q       <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_mux_4to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_mux_4to1
// Purpose  : Self-checking bench for tdm_mux_4to1. Two instances (BURST=4
//            and BURST=1) share valid/ready stimulus; each has its own data
//            bus carrying per-channel sequence numbers. A credit-based
//            reference model predicts grants and the output register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_mux_4to1;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data0, in_data1;
  logic           out_ready;

  logic [3:0]     rdy0, rdy1;
  logic           ov0, ov1;
  logic [W-1:0]   od0, od1;
  logic [1:0]     os0, os1;

  tdm_mux_4to1 #(.WIDTH(W), .BURST(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data0),
    .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_sel(os0),
    .out_ready(out_ready)
  );

  tdm_mux_4to1 #(.WIDTH(W), .BURST(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data1),
    .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_sel(os1),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per instance, previous owner, remaining lock credit and
  // the contents of the output register.
  int           bursts [2] = '{4, 1};
  int           m_last [2];
  int           m_left [2];
  logic         m_ov   [2];
  logic [W-1:0] m_od   [2];
  logic [1:0]   m_os   [2];
  logic [W-1:0] seq    [2][4];
  logic [W-1:0] inc;

  // Observations captured in the most recent step (before its clock edge).
  logic [3:0]   obs_rdy [2];
  logic         obs_ov  [2];
  logic [W-1:0] obs_od  [2];
  logic [1:0]   obs_os  [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_last[k] = 3;
    m_left[k] = 0;
    m_ov[k]   = 1'b0;
    m_od[k]   = '0;
    m_os[k]   = 2'd0;
  endtask

  // One cycle: drive at negedge, check just after, model advances for the
  // following posedge.
  task automatic step(input logic r, input logic [3:0] v, input logic ordy);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    out_ready = ordy;
    for (int n = 0; n < 4; n++) begin
      in_data0[n*W +: W] = seq[0][n];
      in_data1[n*W +: W] = seq[1][n];
    end
    #1;
    obs_rdy[0] = rdy0; obs_ov[0] = ov0; obs_od[0] = od0; obs_os[0] = os0;
    obs_rdy[1] = rdy1; obs_ov[1] = ov1; obs_od[1] = od1; obs_os[1] = os1;
    for (int k = 0; k < 2; k++) begin
      int         g;
      logic [3:0] er;
      logic       ld;
      g = -1;
      if (r) model_reset(k);
      chk($sformatf("i%0d_out_valid", k), 32'(obs_ov[k]), 32'(m_ov[k]));
      chk($sformatf("i%0d_out_data", k),  32'(obs_od[k]), 32'(m_od[k]));
      chk($sformatf("i%0d_out_sel", k),   32'(obs_os[k]), 32'(m_os[k]));
      ld = !m_ov[k] || ordy;
      if (!r && ld) begin
        if (m_left[k] > 0) begin
          if (v[m_last[k]]) g = m_last[k];
          else              m_left[k] = 0;   // lock dropped, bubble
        end else begin
          for (int i = 1; i <= 4; i++) begin
            int c;
            c = (m_last[k] + i) % 4;
            if (g < 0 && v[c]) g = c;
          end
        end
      end
      er = (g >= 0) ? 4'(1 << g) : 4'b0000;
      chk($sformatf("i%0d_in_ready", k), 32'(obs_rdy[k]), 32'(er));
      if (g >= 0) begin
        if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
        else               m_left[k] = bursts[k] - 1;
        m_last[k] = g;
        m_ov[k]   = 1'b1;
        m_od[k]   = seq[k][g];
        m_os[k]   = 2'(g);
        seq[k][g] = seq[k][g] + inc;
      end else if (!r && ld) begin
        m_ov[k] = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b0; out_ready = 1'b0;
    in_data0 = '0; in_data1 = '0;
    inc = 8'd1;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      for (int n = 0; n < 4; n++) seq[k][n] = 8'(n * 64);
    end

    // Reset with every channel requesting; first grant afterwards is ch0.
    step(1'b1, 4'b1111, 1'b1);
    chk("rst_out_valid", 32'(obs_ov[0]), 32'd0);
    chk("rst_in_ready",  32'(obs_rdy[0] | obs_rdy[1]), 32'd0);
    chk("rst_out_sel",   32'(obs_os[0]), 32'd0);

    // Locked round-robin on instance 0, pure round-robin on instance 1.
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 4'b1111, 1'b1);
      if (j == 0) chk("first_grant_ch0", 32'(obs_rdy[0]), 32'b0001);
      if (j >= 1) begin
        chk("rr_burst4_sel", 32'(obs_os[0]), 32'(((j - 1) / 4) % 4));
        chk("rr_burst1_sel", 32'(obs_os[1]), 32'((j - 1) % 4));
        chk("rr_no_gap",     32'(obs_ov[0] & obs_ov[1]), 32'd1);
      end
    end

    // Single channel 2 stream: 0x11, 0x22, 0x33 with no bubbles.
    step(1'b1, 4'b0000, 1'b1);
    inc = 8'h11;
    seq[0][2] = 8'h11; seq[1][2] = 8'h11;
    for (int j = 0; j < 4; j++) begin
      step(1'b0, (j < 3) ? 4'b0100 : 4'b0000, 1'b1);
      if (j >= 1) begin
        for (int k = 0; k < 2; k++) begin
          chk("single_data",  32'(obs_od[k]), 32'(8'h11 * j));
          chk("single_sel",   32'(obs_os[k]), 32'd2);
          chk("single_valid", 32'(obs_ov[k]), 32'd1);
        end
      end
    end

    // Backpressure: 0xA5 held for five stalled cycles.
    step(1'b1, 4'b0000, 1'b1);
    inc = 8'd1;
    seq[0][0] = 8'hA5; seq[1][0] = 8'hA5;
    step(1'b0, 4'b0001, 1'b1);
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 4'b1111, 1'b0);
      chk("stall_data",  32'(obs_od[0]), 32'hA5);
      chk("stall_sel",   32'(obs_os[0]), 32'd0);
      chk("stall_ready", 32'(obs_rdy[0]), 32'd0);
      chk("stall_valid", 32'(obs_ov[0]), 32'd1);
    end
    for (int j = 0; j < 6; j++) step(1'b0, 4'b1111, 1'b1);

    // Lock drop: ch1 leaves after two beats, one bubble, then ch2.
    step(1'b1, 4'b0000, 1'b1);
    step(1'b0, 4'b0110, 1'b1);
    step(1'b0, 4'b0110, 1'b1);
    step(1'b0, 4'b0100, 1'b1);
    chk("drop_no_grant", 32'(obs_rdy[0]), 32'd0);
    step(1'b0, 4'b0100, 1'b1);
    chk("drop_bubble",   32'(obs_ov[0]), 32'd0);
    chk("drop_grant_c2", 32'(obs_rdy[0]), 32'b0100);
    step(1'b0, 4'b0000, 1'b1);
    chk("drop_sel_c2",   32'(obs_os[0]), 32'd2);

    // Reset mid-burst.
    step(1'b0, 4'b1110, 1'b1);
    step(1'b0, 4'b1110, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    chk("midrst_valid", 32'(obs_ov[0]), 32'd0);
    step(1'b0, 4'b1111, 1'b1);
    chk("midrst_ch0",   32'(obs_rdy[0]), 32'b0001);

    // Randomized traffic with occasional resets.
    for (int j = 0; j < 3000; j++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           4'($urandom),
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
